// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes for serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] value_a;
    logic [WIDTH-1:0] value_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow;

    modport master (
        output in_valid, value_a, value_b, out_ready,
        input  in_ready, out_valid, difference, borrow
    );

    modport slave (
        input  in_valid, value_a, value_b, out_ready,
        output in_ready, out_valid, difference, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Unsigned WIDTH-bit subtractor computing CHUNK bits per cycle,
// least-significant slice first, with a rippled borrow between slices.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int K  = WIDTH / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] diff_q;
    logic [IW-1:0]    idx_q;
    logic             brw_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CHUNK:0]   slice;

    // Operands shift down so the active slice is always at bit 0;
    // finished slices enter the working register from the top.
    always_comb begin
        slice = {1'b0, a_q[CHUNK-1:0]}
              - {1'b0, b_q[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, brw_q};
        work_next = WIDTH'({slice[CHUNK-1:0], work_q} >> CHUNK);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.in_valid && in_ready_q) state_next = BUSY;
            BUSY: if (idx_q == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            brw_q       <= 1'b0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == IDLE);
            out_valid_q <= (state_next == DONE);
            if (state == IDLE && state_next == BUSY) begin
                a_q    <= bus.value_a;
                b_q    <= bus.value_b;
                work_q <= '0;
                idx_q  <= '0;
                brw_q  <= 1'b0;
            end else if (state == BUSY) begin
                a_q    <= a_q >> CHUNK;
                b_q    <= b_q >> CHUNK;
                work_q <= work_next;
                brw_q  <= slice[CHUNK];
                idx_q  <= idx_q + 1'b1;
                if (state_next == DONE) begin
                    diff_q   <= work_next;
                    borrow_q <= slice[CHUNK];
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.difference = diff_q;
    assign bus.borrow     = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors on a 32/8 instance and
// randomised streaming against a queue model on three configurations.
module tb_serial_subtractor;
    localparam int N_RAND = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic rst_d;
    serial_subtractor_if #(.WIDTH(32)) bus_d ();
    serial_subtractor #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk),
        .rst(rst_d),
        .bus(bus_d)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        brw;
    } vec_t;

    vec_t vecs [7];

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_b,
                          input string tag);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, bus_d.in_ready, 1);
        bus_d.in_valid  = 1'b1;
        bus_d.value_a   = a;
        bus_d.value_b   = b;
        bus_d.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            bus_d.in_valid = 1'b0;
            bus_d.value_a  = '1;
            bus_d.value_b  = '0;
            lat++;
        end while (!bus_d.out_valid && lat < 20);
        check({tag, " latency"}, lat, 5);
        check({tag, " difference"}, bus_d.difference, exp_d);
        check({tag, " borrow"}, bus_d.borrow, exp_b);
        @(negedge clk);
        check({tag, " out_valid drop"}, bus_d.out_valid, 0);
        check({tag, " in_ready back"}, bus_d.in_ready, 1);
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : cfg
            localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 12;
            localparam int C = (g == 0) ? 8 : (g == 1) ? 16 : 4;

            logic rst_r;
            logic done_r = 1'b0;
            serial_subtractor_if #(.WIDTH(W)) bus ();
            serial_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
                .clk(clk),
                .rst(rst_r),
                .bus(bus)
            );

            logic [W-1:0] q_d [$];
            logic         q_b [$];

            initial begin
                int   sent;
                int   got;
                int   cyc;
                logic fire;
                logic [W-1:0] ed;
                logic eb;
                rst_r          = 1'b1;
                bus.in_valid   = 1'b0;
                bus.out_ready  = 1'b0;
                bus.value_a    = '0;
                bus.value_b    = '0;
                repeat (2) @(negedge clk);
                rst_r = 1'b0;
                sent = 0;
                got  = 0;
                cyc  = 0;
                fire = 1'b0;
                while (got < N_RAND && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (fire) bus.in_valid = 1'b0;
                    if (!bus.in_valid && sent < N_RAND &&
                        $urandom_range(0, 2) != 0) begin
                        bus.in_valid = 1'b1;
                        bus.value_a  = W'($urandom);
                        bus.value_b  = W'($urandom);
                        case ($urandom_range(0, 5))
                            0: bus.value_b = bus.value_a;
                            1: bus.value_a = '0;
                            2: bus.value_b = '1;
                            default: ;
                        endcase
                    end
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    fire = bus.in_valid && bus.in_ready;
                    if (fire) begin
                        q_d.push_back(bus.value_a - bus.value_b);
                        q_b.push_back(bus.value_a < bus.value_b);
                        sent++;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        got++;
                        if (q_d.size() == 0) begin
                            check($sformatf("rand%0d spurious", g), q_d.size(), 1);
                        end else begin
                            ed = q_d.pop_front();
                            eb = q_b.pop_front();
                            check($sformatf("rand%0d diff #%0d", g, got),
                                  32'(bus.difference), 32'(ed));
                            check($sformatf("rand%0d borrow #%0d", g, got),
                                  bus.borrow, eb);
                        end
                    end
                end
                check($sformatf("rand%0d results", g), got, N_RAND);
                check($sformatf("rand%0d leftover", g), q_d.size(), 0);
                done_r = 1'b1;
            end
        end
    endgenerate

    initial begin
        int  lat;
        logic seen;
        vecs[0] = '{32'h0000_1234, 32'h0000_0234, 32'h0000_1000, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
        vecs[5] = '{32'h0000_00FF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1};

        rst_d           = 1'b1;
        bus_d.in_valid  = 1'b0;
        bus_d.out_ready = 1'b0;
        bus_d.value_a   = '0;
        bus_d.value_b   = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset in_ready", bus_d.in_ready, 0);
            check("reset out_valid", bus_d.out_valid, 0);
            check("reset difference", bus_d.difference, 0);
            check("reset borrow", bus_d.borrow, 0);
        end
        rst_d = 1'b0;
        #1;
        check("release in_ready before edge", bus_d.in_ready, 0);
        @(negedge clk);
        check("release in_ready after edge", bus_d.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].brw,
                   $sformatf("vec%0d", i));
        end

        // backpressure
        @(negedge clk);
        bus_d.in_valid  = 1'b1;
        bus_d.value_a   = 32'd5;
        bus_d.value_b   = 32'd7;
        bus_d.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            bus_d.in_valid = 1'b0;
            lat++;
        end while (!bus_d.out_valid && lat < 20);
        check("bp latency", lat, 5);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("bp hold valid %0d", i), bus_d.out_valid, 1);
            check($sformatf("bp hold diff %0d", i), bus_d.difference, 32'hFFFF_FFFE);
            check($sformatf("bp hold borrow %0d", i), bus_d.borrow, 1);
            check($sformatf("bp in_ready %0d", i), bus_d.in_ready, 0);
            bus_d.in_valid = (i == 2);
            bus_d.value_a  = 32'd100;
            bus_d.value_b  = 32'd1;
            if (i == 6) bus_d.out_ready = 1'b1;
            @(negedge clk);
        end
        check("bp handshake out_valid", bus_d.out_valid, 0);
        check("bp handshake in_ready", bus_d.in_ready, 1);
        check("bp diff kept", bus_d.difference, 32'hFFFF_FFFE);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_d.out_valid) seen = 1'b1;
        end
        check("bp pulse ignored", seen, 0);
        run_op(32'd4, 32'd9, 32'hFFFF_FFFB, 1'b1, "post bp");

        // reset during BUSY
        @(negedge clk);
        bus_d.in_valid  = 1'b1;
        bus_d.value_a   = 32'd10;
        bus_d.value_b   = 32'd3;
        bus_d.out_ready = 1'b1;
        @(negedge clk);
        bus_d.in_valid = 1'b0;
        @(negedge clk);
        rst_d = 1'b1;
        #1;
        check("midrst in_ready", bus_d.in_ready, 0);
        check("midrst out_valid", bus_d.out_valid, 0);
        check("midrst difference", bus_d.difference, 0);
        check("midrst borrow", bus_d.borrow, 0);
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_d.out_valid) seen = 1'b1;
        end
        check("midrst no result", seen, 0);
        run_op(32'd10, 32'd3, 32'd7, 1'b0, "after midrst");

        for (int c = 0; c < 20000; c++) begin
            if (cfg[0].done_r && cfg[1].done_r && cfg[2].done_r) break;
            @(negedge clk);
        end
        check("rand streams finished",
              {cfg[0].done_r, cfg[1].done_r, cfg[2].done_r}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
